// File: rtl/coeff_block_reader_pkg.sv
// rtl/coeff_block_reader_pkg.sv - shared zigzag table, default sizes and FSM encoding
package coeff_block_reader_pkg;

  localparam int DEF_WIDTH      = 9;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DEPTH      = 16;

  // Element [pos] is the raster address of zigzag scan position pos.
  localparam logic [15:0][3:0] ZIGZAG = {
    4'd15, 4'd14, 4'd11, 4'd7, 4'd10, 4'd13, 4'd12, 4'd9,
    4'd6,  4'd3,  4'd2,  4'd5, 4'd8,  4'd4,  4'd1,  4'd0
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [3:0] zigzag_addr(input logic [3:0] pos);
    return ZIGZAG[pos];
  endfunction

endpackage

// File: rtl/coeff_skid_fifo.sv
// rtl/coeff_skid_fifo.sv - 3-entry FIFO absorbing BRAM read latency under backpressure
module coeff_skid_fifo #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [3];
  logic [1:0]   r_wr_ptr;
  logic [1:0]   r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;
  // Head is forced to zero when empty so a cleared FIFO presents all-zero outputs.
  assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 2'd0;
      for (int i = 0; i < 3; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/coeff_block_reader.sv
// rtl/coeff_block_reader.sv - zigzag read sequencer from coefficient BRAM port B to a valid/ready stream
module coeff_block_reader
  import coeff_block_reader_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int addrWIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter bit REVERSE   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 enb,
  output logic [addrWIDTH-1:0] addrb,
  input  logic [WIDTH-1:0]     dob,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [3:0]           m_index,
  output logic                 m_last
);

  state_t               r_state;
  state_t               w_next_state;
  logic [4:0]           r_issued;
  logic                 r_cap_valid;
  logic [3:0]           r_cap_index;
  logic                 r_cap_last;
  logic [addrWIDTH-1:0] r_addrb;
  logic                 r_done;

  logic                 w_enb;
  logic                 w_pop;
  logic                 w_start_ok;
  logic                 w_room;
  logic                 w_issue_last;
  logic [3:0]           w_scan;
  logic [1:0]           w_occ;
  logic                 w_fifo_valid;
  logic [WIDTH+4:0]     w_head;

  assign w_scan       = REVERSE ? ~r_issued[3:0] : r_issued[3:0];
  assign w_issue_last = (r_issued == 5'(DEPTH - 1));
  assign w_pop        = w_fifo_valid && m_ready;
  // The done cycle is already IDLE, so it must be excluded explicitly.
  assign w_start_ok   = (r_state == ST_IDLE) && start && !r_done;
  // Buffered plus in-flight elements may never exceed the 3 FIFO slots.
  assign w_room       = ({1'b0, w_occ} + {2'b00, r_cap_valid}) < (3'd3 + {2'b00, w_pop});

  always_comb begin
    w_next_state = r_state;
    w_enb        = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_start_ok) w_next_state = ST_READ;
      ST_READ: begin
        if (w_room) begin
          w_enb = 1'b1;
          if (w_issue_last) w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: if (w_pop && m_last) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_issued    <= 5'd0;
      r_cap_valid <= 1'b0;
      r_cap_index <= 4'd0;
      r_cap_last  <= 1'b0;
      r_addrb     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_done      <= (r_state == ST_DRAIN) && w_pop && m_last;
      r_cap_valid <= w_enb;
      if (w_start_ok) r_issued <= 5'd0;
      else if (w_enb) r_issued <= r_issued + 5'd1;
      if (w_enb) begin
        r_cap_index <= w_scan;
        r_cap_last  <= w_issue_last;
        r_addrb     <= addrWIDTH'(zigzag_addr(w_scan));
      end
    end
  end

  assign busy  = (r_state != ST_IDLE);
  assign done  = r_done;
  assign enb   = w_enb;
  assign addrb = w_enb ? addrWIDTH'(zigzag_addr(w_scan)) : r_addrb;

  coeff_skid_fifo #(.W(WIDTH + 5)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_cap_valid),
    .i_data  ({r_cap_last, r_cap_index, dob}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_valid (w_fifo_valid),
    .o_count (w_occ)
  );

  assign m_valid = w_fifo_valid;
  assign m_last  = w_head[WIDTH+4];
  assign m_index = w_head[WIDTH+3:WIDTH];
  assign m_data  = w_head[WIDTH-1:0];

endmodule
